// File: rtl/axi4_sub_mem_if.sv
// AXI4 bus interface shared by managers and subordinates.
// Carries the AW/W/B/AR/R channels used by the scratch memory.
interface axi4_bus_if #(
  parameter int AXI4_ADDR_WIDTH = 32,
  parameter int AXI4_DATA_WIDTH = 64,
  parameter int AXI4_ID_WIDTH   = 4
);
  localparam int AW = AXI4_ADDR_WIDTH;
  localparam int DW = AXI4_DATA_WIDTH;
  localparam int IW = AXI4_ID_WIDTH;

  logic [IW-1:0]   aw_id;
  logic [AW-1:0]   aw_addr;
  logic [7:0]      aw_len;
  logic [2:0]      aw_size;
  logic [1:0]      aw_burst;
  logic            aw_valid;
  logic            aw_ready;

  logic [DW-1:0]   w_data;
  logic [DW/8-1:0] w_strb;
  logic            w_last;
  logic            w_valid;
  logic            w_ready;

  logic [IW-1:0]   b_id;
  logic [1:0]      b_resp;
  logic            b_valid;
  logic            b_ready;

  logic [IW-1:0]   ar_id;
  logic [AW-1:0]   ar_addr;
  logic [7:0]      ar_len;
  logic [2:0]      ar_size;
  logic [1:0]      ar_burst;
  logic            ar_valid;
  logic            ar_ready;

  logic [IW-1:0]   r_id;
  logic [DW-1:0]   r_data;
  logic [1:0]      r_resp;
  logic            r_last;
  logic            r_valid;
  logic            r_ready;

  modport Manager (
    output aw_id, aw_addr, aw_len,
    output aw_size, aw_burst, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len,
    output ar_size, ar_burst, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_valid,
    output r_ready
  );

  modport Subordinate (
    input  aw_id, aw_addr, aw_len,
    input  aw_size, aw_burst, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_valid,
    output w_ready,
    output b_id, b_resp, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len,
    input  ar_size, ar_burst, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_valid,
    input  r_ready
  );
endinterface

// File: rtl/axi4_sub_mem.sv
// AXI4 subordinate backed by a word-wide register array.
// Independent read/write FSMs, INCR full-width bursts, per-beat errors.
module axi4_sub_mem #(
  parameter int AXI4_ADDR_WIDTH = 32,
  parameter int AXI4_DATA_WIDTH = 64,
  parameter int AXI4_ID_WIDTH   = 4,
  parameter int MEM_DEPTH       = 256,
  parameter logic [AXI4_ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input logic             clk_i,
  input logic             rstn_i,
  axi4_bus_if.Subordinate axi_sub_if
);
  localparam int AW        = AXI4_ADDR_WIDTH;
  localparam int DW        = AXI4_DATA_WIDTH;
  localparam int IW        = AXI4_ID_WIDTH;
  localparam int WordBytes = DW / 8;
  localparam int Lsb       = $clog2(WordBytes);
  localparam int IdxW      = $clog2(MEM_DEPTH);

  localparam logic [AW:0]   Span   = (AW+1)'(MEM_DEPTH * WordBytes);
  localparam logic [AW-1:0] Step   = AW'(WordBytes);
  localparam logic [2:0]    SizeOk = 3'(Lsb);
  localparam logic [1:0]    Okay   = 2'b00;
  localparam logic [1:0]    SlvErr = 2'b10;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

  logic [DW-1:0] r_mem [MEM_DEPTH];

  logic [1:0]    r_wst;
  logic          r_awready;
  logic          r_wready;
  logic          r_bvalid;
  logic [1:0]    r_bresp;
  logic [IW-1:0] r_bid;
  logic [IW-1:0] r_wid;
  logic [AW-1:0] r_waddr;
  logic [7:0]    r_wlen;
  logic [7:0]    r_wcnt;
  logic          r_wflag;
  logic          r_werr;

  logic [AW-1:0]   w_woff;
  logic            w_winr;
  logic [IdxW-1:0] w_widx;
  logic            w_awbad;
  logic            w_wbeat;
  logic            w_wend;
  logic            w_werr_nx;

  assign w_woff  = r_waddr - BASE_ADDR;
  assign w_winr  = {1'b0, w_woff} < Span;
  assign w_widx  = IdxW'(w_woff >> Lsb);
  assign w_awbad = (axi_sub_if.aw_burst != 2'b01)
                || (axi_sub_if.aw_size != SizeOk);
  assign w_wbeat = r_wready && axi_sub_if.w_valid;
  assign w_wend  = (r_wcnt == r_wlen);
  // A mismatched w_last only flags the burst; the beat count decides the end.
  assign w_werr_nx = r_werr | ~w_winr
                   | (axi_sub_if.w_last != w_wend);

  always_ff @(posedge clk_i) begin
    if (w_wbeat && !r_wflag && w_winr) begin
      for (int k = 0; k < WordBytes; k++) begin
        if (axi_sub_if.w_strb[k]) begin
          r_mem[w_widx][8*k +: 8] <= axi_sub_if.w_data[8*k +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_wst     <= W_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= Okay;
      r_bid     <= '0;
      r_wid     <= '0;
      r_waddr   <= '0;
      r_wlen    <= '0;
      r_wcnt    <= '0;
      r_wflag   <= 1'b0;
      r_werr    <= 1'b0;
    end else begin
      unique case (r_wst)
        W_IDLE: begin
          r_awready <= 1'b1;
          if (axi_sub_if.aw_valid && r_awready) begin
            r_awready <= 1'b0;
            r_wready  <= 1'b1;
            r_waddr   <= axi_sub_if.aw_addr;
            r_wlen    <= axi_sub_if.aw_len;
            r_wid     <= axi_sub_if.aw_id;
            r_wcnt    <= '0;
            r_wflag   <= w_awbad;
            r_werr    <= w_awbad;
            r_wst     <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_wbeat) begin
            r_waddr <= r_waddr + Step;
            r_wcnt  <= r_wcnt + 8'd1;
            r_werr  <= w_werr_nx;
            if (w_wend) begin
              r_wready <= 1'b0;
              r_bvalid <= 1'b1;
              r_bresp  <= w_werr_nx ? SlvErr : Okay;
              r_bid    <= r_wid;
              r_wst    <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (axi_sub_if.b_ready) begin
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_wst     <= W_IDLE;
          end
        end
        default: r_wst <= W_IDLE;
      endcase
    end
  end

  logic [0:0]    r_rst;
  logic          r_arready;
  logic          r_rvalid;
  logic          r_rlast;
  logic [1:0]    r_rresp;
  logic [IW-1:0] r_rid;
  logic [DW-1:0] r_rdata;
  logic [AW-1:0] r_rnext;
  logic [7:0]    r_rlen;
  logic [7:0]    r_rcnt;
  logic          r_rflag;

  logic            w_arbad;
  logic [AW-1:0]   w_raddr;
  logic            w_rbad;
  logic [AW-1:0]   w_roff;
  logic            w_rok;
  logic [IdxW-1:0] w_ridx;

  assign w_arbad = (axi_sub_if.ar_burst != 2'b01)
                || (axi_sub_if.ar_size != SizeOk);
  // One lookup path: the AR address for the first beat, else the next beat.
  assign w_raddr = (r_rst == R_IDLE) ? axi_sub_if.ar_addr : r_rnext;
  assign w_rbad  = (r_rst == R_IDLE) ? w_arbad : r_rflag;
  assign w_roff  = w_raddr - BASE_ADDR;
  assign w_rok   = ({1'b0, w_roff} < Span) && !w_rbad;
  assign w_ridx  = IdxW'(w_roff >> Lsb);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_rst     <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rresp   <= Okay;
      r_rid     <= '0;
      r_rdata   <= '0;
      r_rnext   <= '0;
      r_rlen    <= '0;
      r_rcnt    <= '0;
      r_rflag   <= 1'b0;
    end else begin
      unique case (r_rst)
        R_IDLE: begin
          r_arready <= 1'b1;
          if (axi_sub_if.ar_valid && r_arready) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b1;
            r_rid     <= axi_sub_if.ar_id;
            r_rlen    <= axi_sub_if.ar_len;
            r_rcnt    <= '0;
            r_rflag   <= w_arbad;
            r_rnext   <= axi_sub_if.ar_addr + Step;
            r_rdata   <= w_rok ? r_mem[w_ridx] : '0;
            r_rresp   <= w_rok ? Okay : SlvErr;
            r_rlast   <= (axi_sub_if.ar_len == 8'd0);
            r_rst     <= R_DATA;
          end
        end
        R_DATA: begin
          if (axi_sub_if.r_ready) begin
            if (r_rlast) begin
              r_rvalid  <= 1'b0;
              r_rlast   <= 1'b0;
              r_arready <= 1'b1;
              r_rst     <= R_IDLE;
            end else begin
              r_rnext <= r_rnext + Step;
              r_rcnt  <= r_rcnt + 8'd1;
              r_rdata <= w_rok ? r_mem[w_ridx] : '0;
              r_rresp <= w_rok ? Okay : SlvErr;
              r_rlast <= (r_rcnt + 8'd1 == r_rlen);
            end
          end
        end
        default: r_rst <= R_IDLE;
      endcase
    end
  end

  assign axi_sub_if.aw_ready = r_awready;
  assign axi_sub_if.w_ready  = r_wready;
  assign axi_sub_if.b_valid  = r_bvalid;
  assign axi_sub_if.b_resp   = r_bresp;
  assign axi_sub_if.b_id     = r_bid;
  assign axi_sub_if.ar_ready = r_arready;
  assign axi_sub_if.r_valid  = r_rvalid;
  assign axi_sub_if.r_last   = r_rlast;
  assign axi_sub_if.r_resp   = r_rresp;
  assign axi_sub_if.r_id     = r_rid;
  assign axi_sub_if.r_data   = r_rdata;
endmodule

// File: tb/tb_axi4_sub_mem.sv
// Bench for axi4_sub_mem: random bursts against a byte-level memory model,
// plus directed cases with hand-computed results.
module tb_axi4_sub_mem;
  localparam int AW    = 32;
  localparam int DW    = 64;
  localparam int IW    = 4;
  localparam int DEPTH = 256;
  localparam logic [31:0] BASE = 32'h0;
  localparam logic [31:0] SPAN = 32'(DEPTH * 8);

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  axi4_bus_if #(
    .AXI4_ADDR_WIDTH(AW),
    .AXI4_DATA_WIDTH(DW),
    .AXI4_ID_WIDTH(IW)
  ) bus ();

  axi4_sub_mem #(
    .AXI4_ADDR_WIDTH(AW),
    .AXI4_DATA_WIDTH(DW),
    .AXI4_ID_WIDTH(IW),
    .MEM_DEPTH(DEPTH),
    .BASE_ADDR(BASE)
  ) dut (
    .clk_i(clk),
    .rstn_i(rstn),
    .axi_sub_if(bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Reference model
  logic [63:0] mem_m [DEPTH];

  typedef struct {
    logic [63:0] d;
    logic [1:0]  resp;
    logic        last;
    logic [3:0]  id;
  } rbeat_t;
  typedef struct {
    logic [1:0] resp;
    logic [3:0] id;
  } bexp_t;

  rbeat_t      exp_r[$];
  bexp_t       exp_b[$];
  logic [63:0] rcap[$];
  logic [1:0]  bcap[$];
  logic [63:0] wq_d[$];
  logic [7:0]  wq_s[$];

  function automatic bit inr(input logic [31:0] a);
    logic [31:0] o;
    o = a - BASE;
    return o < SPAN;
  endfunction

  function automatic int widx(input logic [31:0] a);
    logic [31:0] o;
    o = (a - BASE) >> 3;
    return int'(o);
  endfunction

  task automatic fill_wq(input int n, input bit rstrb);
    for (int i = 0; i < n; i++) begin
      wq_d.push_back({$urandom, $urandom});
      wq_s.push_back(rstrb ? 8'($urandom) : 8'hFF);
    end
  endtask

  // Ready drivers
  int rmode = 0;
  int bmode = 0;
  int pidx  = 0;
  int bcnt  = 0;
  logic [3:0] rpat = 4'b1001;

  initial begin
    bus.r_ready = 1'b0;
    bus.b_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      pidx++;
      case (rmode)
        0: bus.r_ready = 1'b1;
        1: bus.r_ready = 1'($urandom_range(0, 1));
        default: bus.r_ready = rpat[pidx % 4];
      endcase
      if (bus.b_valid) bcnt++;
      else bcnt = 0;
      case (bmode)
        0: bus.b_ready = 1'b1;
        1: bus.b_ready = 1'($urandom_range(0, 1));
        default: bus.b_ready = (bcnt > 5);
      endcase
    end
  end

  // Compare process
  rbeat_t      er;
  bexp_t       eb;
  logic [63:0] pr_d;
  logic [1:0]  pr_resp;
  logic        pr_last;
  logic        pr_stall = 1'b0;
  logic [1:0]  pb_resp;
  logic [3:0]  pb_id;
  logic        pb_stall = 1'b0;

  always @(negedge clk) begin
    if (!rstn) begin
      pr_stall = 1'b0;
      pb_stall = 1'b0;
    end else begin
      if (bus.r_valid) begin
        if (pr_stall) begin
          chk("r_hold_data", bus.r_data, pr_d);
          chk("r_hold_resp", 64'(bus.r_resp), 64'(pr_resp));
          chk("r_hold_last", 64'(bus.r_last), 64'(pr_last));
        end
        if (bus.r_ready) begin
          if (exp_r.size() == 0) begin
            chk("r_unexpected", 64'(bus.r_valid), 64'd0);
          end else begin
            er = exp_r.pop_front();
            chk("r_data", bus.r_data, er.d);
            chk("r_resp", 64'(bus.r_resp), 64'(er.resp));
            chk("r_last", 64'(bus.r_last), 64'(er.last));
            chk("r_id", 64'(bus.r_id), 64'(er.id));
            rcap.push_back(bus.r_data);
          end
        end
        pr_stall = !bus.r_ready;
        pr_d     = bus.r_data;
        pr_resp  = bus.r_resp;
        pr_last  = bus.r_last;
      end else begin
        if (pr_stall) chk("r_hold_valid", 64'(bus.r_valid), 64'd1);
        pr_stall = 1'b0;
      end
      if (bus.b_valid) begin
        if (pb_stall) begin
          chk("b_hold_resp", 64'(bus.b_resp), 64'(pb_resp));
          chk("b_hold_id", 64'(bus.b_id), 64'(pb_id));
        end
        if (bus.b_ready) begin
          if (exp_b.size() == 0) begin
            chk("b_unexpected", 64'(bus.b_valid), 64'd0);
          end else begin
            eb = exp_b.pop_front();
            chk("b_resp", 64'(bus.b_resp), 64'(eb.resp));
            chk("b_id", 64'(bus.b_id), 64'(eb.id));
            bcap.push_back(bus.b_resp);
          end
        end
        pb_stall = !bus.b_ready;
        pb_resp  = bus.b_resp;
        pb_id    = bus.b_id;
      end else begin
        if (pb_stall) chk("b_hold_valid", 64'(bus.b_valid), 64'd1);
        pb_stall = 1'b0;
      end
    end
  end

  task automatic do_read(input logic [31:0] a, input logic [7:0] len,
                         input logic [1:0] burst, input logic [2:0] size,
                         input logic [3:0] id);
    bit          flag;
    bit          ok;
    bit          hs;
    int          t;
    logic [31:0] ad;
    rbeat_t      e;
    flag = (burst != 2'b01) || (size != 3'd3);
    ad = a;
    for (int b = 0; b <= int'(len); b++) begin
      ok = !flag && inr(ad);
      e.d = 64'h0;
      if (ok) e.d = mem_m[widx(ad)];
      e.resp = ok ? 2'b00 : 2'b10;
      e.last = (b == int'(len));
      e.id   = id;
      exp_r.push_back(e);
      ad = ad + 32'd8;
    end
    @(posedge clk);
    #1;
    bus.ar_addr  = a;
    bus.ar_len   = len;
    bus.ar_burst = burst;
    bus.ar_size  = size;
    bus.ar_id    = id;
    bus.ar_valid = 1'b1;
    hs = 1'b0;
    t  = 0;
    while (!hs && t < 200) begin
      @(negedge clk);
      hs = bus.ar_ready;
      @(posedge clk);
      t++;
    end
    #1;
    bus.ar_valid = 1'b0;
    if (!hs) begin
      chk("ar_timeout", 64'(hs), 64'd1);
      exp_r.delete();
      return;
    end
    @(negedge clk);
    chk("r_first_latency", 64'(bus.r_valid), 64'd1);
    t = 0;
    while (exp_r.size() != 0 && t < 2000) begin
      @(posedge clk);
      t++;
    end
    if (exp_r.size() != 0) begin
      chk("r_timeout", 64'(exp_r.size()), 64'd0);
      exp_r.delete();
    end
    @(negedge clk);
    chk("r_done_valid", 64'(bus.r_valid), 64'd0);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [7:0] len,
                          input logic [1:0] burst, input logic [2:0] size,
                          input logic [3:0] id, input int badlast,
                          input int abort_after, input bit gaps);
    bit          flag;
    bit          err;
    bit          hs;
    int          t;
    logic [31:0] ad;
    logic [63:0] d;
    logic [7:0]  s;
    flag = (burst != 2'b01) || (size != 3'd3);
    err  = flag;
    ad   = a;
    @(posedge clk);
    #1;
    bus.aw_addr  = a;
    bus.aw_len   = len;
    bus.aw_burst = burst;
    bus.aw_size  = size;
    bus.aw_id    = id;
    bus.aw_valid = 1'b1;
    hs = 1'b0;
    t  = 0;
    while (!hs && t < 200) begin
      @(negedge clk);
      hs = bus.aw_ready;
      @(posedge clk);
      t++;
    end
    #1;
    bus.aw_valid = 1'b0;
    if (!hs) begin
      chk("aw_timeout", 64'(hs), 64'd1);
      wq_d.delete();
      wq_s.delete();
      return;
    end
    for (int b = 0; b <= int'(len); b++) begin
      if (b == abort_after) begin
        wq_d.delete();
        wq_s.delete();
        return;
      end
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
      end
      d = wq_d.pop_front();
      s = wq_s.pop_front();
      bus.w_data  = d;
      bus.w_strb  = s;
      bus.w_last  = (b == int'(len)) ^ (b == badlast);
      bus.w_valid = 1'b1;
      hs = 1'b0;
      t  = 0;
      while (!hs && t < 200) begin
        @(negedge clk);
        hs = bus.w_ready;
        @(posedge clk);
        t++;
      end
      #1;
      bus.w_valid = 1'b0;
      if (!hs) begin
        chk("w_timeout", 64'(hs), 64'd1);
        wq_d.delete();
        wq_s.delete();
        return;
      end
      if (!flag && inr(ad)) begin
        for (int k = 0; k < 8; k++) begin
          if (s[k]) mem_m[widx(ad)][8*k +: 8] = d[8*k +: 8];
        end
      end
      if (!inr(ad)) err = 1'b1;
      if (b == badlast) err = 1'b1;
      ad = ad + 32'd8;
    end
    exp_b.push_back('{err ? 2'b10 : 2'b00, id});
    t = 0;
    while (exp_b.size() != 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    if (exp_b.size() != 0) begin
      chk("b_timeout", 64'(exp_b.size()), 64'd0);
      exp_b.delete();
    end
    @(negedge clk);
    chk("b_done_valid", 64'(bus.b_valid), 64'd0);
  endtask

  logic [31:0] ra;
  logic [7:0]  rl;
  logic [1:0]  rb;
  logic [2:0]  rs;
  int          bl;

  initial begin
    bus.aw_valid = 1'b0;
    bus.aw_addr  = '0;
    bus.aw_len   = '0;
    bus.aw_size  = '0;
    bus.aw_burst = '0;
    bus.aw_id    = '0;
    bus.w_valid  = 1'b0;
    bus.w_data   = '0;
    bus.w_strb   = '0;
    bus.w_last   = 1'b0;
    bus.ar_valid = 1'b0;
    bus.ar_addr  = '0;
    bus.ar_len   = '0;
    bus.ar_size  = '0;
    bus.ar_burst = '0;
    bus.ar_id    = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_aw_ready", 64'(bus.aw_ready), 64'd0);
    chk("rst_w_ready", 64'(bus.w_ready), 64'd0);
    chk("rst_b_valid", 64'(bus.b_valid), 64'd0);
    chk("rst_ar_ready", 64'(bus.ar_ready), 64'd0);
    chk("rst_r_valid", 64'(bus.r_valid), 64'd0);
    chk("rst_r_last", 64'(bus.r_last), 64'd0);
    chk("rst_r_data", bus.r_data, 64'd0);
    chk("rst_b_resp", 64'(bus.b_resp), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_aw_ready", 64'(bus.aw_ready), 64'd1);

    // Directed: 4-beat write/read at 0
    for (int i = 1; i <= 4; i++) begin
      wq_d.push_back(64'(i * 'h11));
      wq_s.push_back(8'hFF);
    end
    bcap.delete();
    do_write(32'h0, 8'd3, 2'b01, 3'd3, 4'h5, -1, -1, 1'b0);
    chk("t1_bresp", 64'(bcap[0]), 64'd0);
    chk("t1_model_w3", mem_m[3], 64'h44);
    rcap.delete();
    do_read(32'h0, 8'd3, 2'b01, 3'd3, 4'h6);
    chk("t1_d0", rcap[0], 64'h11);
    chk("t1_d1", rcap[1], 64'h22);
    chk("t1_d2", rcap[2], 64'h33);
    chk("t1_d3", rcap[3], 64'h44);

    // Give every word a known value
    fill_wq(252, 1'b0);
    do_write(32'h20, 8'd251, 2'b01, 3'd3, 4'h1, -1, -1, 1'b0);

    // Strobed partial write
    wq_d.push_back(64'hFFFF_FFFF_FFFF_FFFF);
    wq_s.push_back(8'hFF);
    do_write(32'h8, 8'd0, 2'b01, 3'd3, 4'h2, -1, -1, 1'b0);
    wq_d.push_back(64'h0);
    wq_s.push_back(8'h0F);
    do_write(32'h8, 8'd0, 2'b01, 3'd3, 4'h2, -1, -1, 1'b0);
    rcap.delete();
    do_read(32'h8, 8'd0, 2'b01, 3'd3, 4'h3);
    chk("t2_partial", rcap[0], 64'hFFFF_FFFF_0000_0000);

    // Back-pressure on R and B
    fill_wq(8, 1'b0);
    do_write(32'h100, 8'd7, 2'b01, 3'd3, 4'h7, -1, -1, 1'b0);
    rmode = 2;
    do_read(32'h100, 8'd7, 2'b01, 3'd3, 4'h8);
    rmode = 0;
    bmode = 2;
    fill_wq(2, 1'b0);
    do_write(32'h180, 8'd1, 2'b01, 3'd3, 4'h9, -1, -1, 1'b0);
    bmode = 0;

    // Top of memory crossing out of range
    rcap.delete();
    do_read(32'h7F8, 8'd1, 2'b01, 3'd3, 4'hA);
    chk("t4_rd_oor", rcap[1], 64'h0);
    wq_d.push_back(64'hA5A5_0000_1234_5678);
    wq_s.push_back(8'hFF);
    wq_d.push_back(64'h5A5A_5A5A_5A5A_5A5A);
    wq_s.push_back(8'hFF);
    bcap.delete();
    do_write(32'h7F8, 8'd1, 2'b01, 3'd3, 4'hB, -1, -1, 1'b0);
    chk("t4_bresp", 64'(bcap[0]), 64'h2);
    rcap.delete();
    do_read(32'h7F8, 8'd0, 2'b01, 3'd3, 4'hC);
    chk("t4_word255", rcap[0], 64'hA5A5_0000_1234_5678);

    // Illegal burst type / size
    bcap.delete();
    fill_wq(2, 1'b0);
    do_write(32'h40, 8'd1, 2'b10, 3'd3, 4'h1, -1, -1, 1'b0);
    fill_wq(2, 1'b0);
    do_write(32'h40, 8'd1, 2'b01, 3'd2, 4'h2, -1, -1, 1'b0);
    chk("t5_wrap_bresp", 64'(bcap[0]), 64'h2);
    chk("t5_size_bresp", 64'(bcap[1]), 64'h2);
    do_read(32'h40, 8'd1, 2'b01, 3'd3, 4'h3);
    do_read(32'h40, 8'd3, 2'b00, 3'd3, 4'h4);

    // Wrong w_last position
    fill_wq(4, 1'b0);
    do_write(32'h300, 8'd3, 2'b01, 3'd3, 4'h5, 1, -1, 1'b0);
    do_read(32'h300, 8'd3, 2'b01, 3'd3, 4'h6);

    // AW and AR in the same cycle on disjoint words
    fill_wq(6, 1'b1);
    fork
      do_write(32'h80, 8'd5, 2'b01, 3'd3, 4'h7, -1, -1, 1'b1);
      do_read(32'h500, 8'd5, 2'b01, 3'd3, 4'h8);
    join
    do_read(32'h80, 8'd5, 2'b01, 3'd3, 4'h9);

    // Random traffic
    rmode = 1;
    bmode = 1;
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 9))
        0: ra = 32'h7C0 + 32'(8 * $urandom_range(0, 7));
        1: ra = 32'h800 + 32'(8 * $urandom_range(0, 4));
        2: ra = 32'hFFFF_FFE0;
        default: ra = 32'(8 * $urandom_range(0, 255))
                    + 32'($urandom_range(0, 7));
      endcase
      rl = 8'($urandom_range(0, 15));
      rb = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 3)) : 2'b01;
      rs = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'd3;
      bl = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, int'(rl))) : -1;
      if ($urandom_range(0, 1) == 1) begin
        fill_wq(int'(rl) + 1, 1'b1);
        do_write(ra, rl, rb, rs, 4'($urandom), bl, -1, 1'b1);
      end else begin
        do_read(ra, rl, rb, rs, 4'($urandom));
      end
    end
    rmode = 0;
    bmode = 0;

    // Reset in the middle of a 16-beat write
    fill_wq(16, 1'b0);
    do_write(32'h200, 8'd15, 2'b01, 3'd3, 4'hD, -1, 5, 1'b0);
    rstn = 1'b0;
    #2;
    chk("t6_aw_ready", 64'(bus.aw_ready), 64'd0);
    chk("t6_w_ready", 64'(bus.w_ready), 64'd0);
    chk("t6_b_valid", 64'(bus.b_valid), 64'd0);
    chk("t6_r_valid", 64'(bus.r_valid), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_aw_ready_rel", 64'(bus.aw_ready), 64'd1);
    chk("t6_ar_ready_rel", 64'(bus.ar_ready), 64'd1);
    repeat (3) @(posedge clk);
    do_read(32'h200, 8'd15, 2'b01, 3'd3, 4'hE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
